// File: rtl/ex_alu_ctrl.sv
// ex_alu_ctrl: issue/writeback controller for the two-stage integer ALU.
// Holds one op in stage 1 and buffers results in a 2-entry in-order FIFO.
module ex_alu_ctrl #(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [2:0]       issue_unit,
   input  logic [1:0]       issue_op,
   input  logic [63:0]      issue_in1,
   input  logic [63:0]      issue_in2,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             alu_enable,
   output logic [2:0]       alu_unit,
   output logic [1:0]       alu_op,
   output logic [63:0]      alu_in1,
   output logic [63:0]      alu_in2,
   input  logic [63:0]      alu_out,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [63:0]      wb_data,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_err,
   output logic             busy
);
   logic             s1_valid;
   logic [2:0]       s1_unit;
   logic [1:0]       s1_op;
   logic [63:0]      s1_in1, s1_in2;
   logic [TAG_W-1:0] s1_tag;
   logic [63:0]      buf_data [2];
   logic [TAG_W-1:0] buf_tag [2];
   logic [1:0]       buf_err;
   logic             rd_ptr, wr_ptr;
   logic [1:0]       count;
   logic             pop, space, advance, accept;

   assign wb_valid    = count != 2'd0;
   assign pop         = wb_valid & wb_ready;
   assign space       = (count < 2'd2) | pop;
   assign advance     = s1_valid & space;
   assign issue_ready = ~flush & (~s1_valid | space);
   assign accept      = issue_valid & issue_ready;
   assign busy        = s1_valid | wb_valid;

   assign alu_enable = s1_valid;
   assign alu_unit   = s1_valid ? s1_unit : 3'd0;
   assign alu_op     = s1_valid ? s1_op : 2'd0;
   assign alu_in1    = s1_valid ? s1_in1 : 64'd0;
   assign alu_in2    = s1_valid ? s1_in2 : 64'd0;

   assign wb_data = wb_valid ? buf_data[rd_ptr] : 64'd0;
   assign wb_tag  = wb_valid ? buf_tag[rd_ptr] : '0;
   assign wb_err  = wb_valid & buf_err[rd_ptr];

   // Flush discards everything; a same-cycle pop needs no special care since state clears.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         s1_valid <= 1'b0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         if (accept) s1_valid <= 1'b1;
         else if (advance) s1_valid <= 1'b0;
         if (advance) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, advance} - {1'b0, pop};
      end
   end

   // Payload registers need no reset: every consumer is gated by a valid or count.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_unit <= issue_unit;
         s1_op   <= issue_op;
         s1_in1  <= issue_in1;
         s1_in2  <= issue_in2;
         s1_tag  <= issue_tag;
      end
      if (advance) begin
         buf_data[wr_ptr] <= alu_out;
         buf_tag[wr_ptr]  <= s1_tag;
         buf_err[wr_ptr]  <= s1_unit[2];
      end
   end
endmodule

// File: tb/tb_ex_alu_ctrl.sv
// tb_ex_alu_ctrl: directed tests for ex_alu_ctrl with a behavioural ALU stage-1 model.
module tb_ex_alu_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [2:0]  issue_unit = '0;
   logic [1:0]  issue_op = '0;
   logic [63:0] issue_in1 = '0;
   logic [63:0] issue_in2 = '0;
   logic [5:0]  issue_tag = '0;
   logic        alu_enable;
   logic [2:0]  alu_unit;
   logic [1:0]  alu_op;
   logic [63:0] alu_in1, alu_in2, alu_out;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [63:0] wb_data;
   logic [5:0]  wb_tag;
   logic        wb_err;
   logic        busy;
   int          passed = 0;
   int          total = 0;

   ex_alu_ctrl #(.TAG_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
      .issue_op(issue_op), .issue_in1(issue_in1), .issue_in2(issue_in2), .issue_tag(issue_tag),
      .alu_enable(alu_enable), .alu_unit(alu_unit), .alu_op(alu_op),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
      .wb_err(wb_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // ALU stage-1 model: unit 0 add/sub, 1 signed less-than, 2 shift left, 3 and; illegal units give 0.
   always_comb begin
      alu_out = 64'd0;
      if (alu_enable)
         case (alu_unit)
            3'd0: alu_out = alu_op[0] ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
            3'd1: alu_out = {63'd0, $signed(alu_in1) < $signed(alu_in2)};
            3'd2: alu_out = alu_in1 << alu_in2[5:0];
            3'd3: alu_out = alu_in1 & alu_in2;
            default: alu_out = 64'd0;
         endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] u, input logic [1:0] o,
                        input logic [63:0] a, input logic [63:0] b, input logic [5:0] t);
      issue_valid = v;
      issue_unit  = u;
      issue_op    = o;
      issue_in1   = a;
      issue_in2   = b;
      issue_tag   = t;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++; if (issue_ready !== 1'b1) $display("FAIL rst_issue_ready got=%b exp=1", issue_ready); else passed++;
      total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); else passed++;
      total++; if (alu_enable !== 1'b0) $display("FAIL rst_alu_enable got=%b exp=0", alu_enable); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
      total++; if ({wb_data, wb_tag, wb_err} !== 71'd0) $display("FAIL rst_wb_fields got=%h/%h/%b exp=0", wb_data, wb_tag, wb_err); else passed++;
      total++; if ({alu_unit, alu_op, alu_in1, alu_in2} !== 133'd0) $display("FAIL rst_alu_fields got=%h/%h/%h/%h exp=0", alu_unit, alu_op, alu_in1, alu_in2); else passed++;
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b1;
      drive(1'b1, 3'd0, 2'd0, 64'd5, 64'd3, 6'd1);
      total++; if (issue_ready !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", issue_ready); else passed++;
      tick();
      drive(1'b1, 3'd0, 2'd1, 64'd5, 64'd3, 6'd2);
      total++; if (alu_enable !== 1'b1 || alu_in1 !== 64'd5 || alu_in2 !== 64'd3) $display("FAIL b2b_alu1 got=%b/%0h/%0h exp=1/5/3", alu_enable, alu_in1, alu_in2); else passed++;
      total++; if (wb_valid !== 1'b0) $display("FAIL b2b_wbv1 got=%b exp=0", wb_valid); else passed++;
      tick();
      drive(1'b1, 3'd1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd3);
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd8 || wb_tag !== 6'd1) $display("FAIL b2b_c2 got=%b/%0h/%0d exp=1/8/1", wb_valid, wb_data, wb_tag); else passed++;
      tick();
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd2 || wb_tag !== 6'd2) $display("FAIL b2b_c3 got=%b/%0h/%0d exp=1/2/2", wb_valid, wb_data, wb_tag); else passed++;
      tick();
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd1 || wb_tag !== 6'd3) $display("FAIL b2b_c4 got=%b/%0h/%0d exp=1/1/3", wb_valid, wb_data, wb_tag); else passed++;
      tick();
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_idle got=%b/%b exp=0/0", wb_valid, busy); else passed++;
   endtask

   task automatic test_backpressure();
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd0, 2'd0, 64'(i + 1), 64'(i + 1), 6'(10 + i));
         total++; if (issue_ready !== 1'b1) $display("FAIL bp_accept%0d got=%b exp=1", i, issue_ready); else passed++;
         tick();
      end
      drive(1'b1, 3'd0, 2'd0, 64'd4, 64'd4, 6'd13);
      total++; if (issue_ready !== 1'b0) $display("FAIL bp_stall0 got=%b exp=0", issue_ready); else passed++;
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd2 || wb_tag !== 6'd10) $display("FAIL bp_head got=%b/%0h/%0d exp=1/2/10", wb_valid, wb_data, wb_tag); else passed++;
      tick();
      total++; if (issue_ready !== 1'b0) $display("FAIL bp_stall1 got=%b exp=0", issue_ready); else passed++;
      total++; if (wb_tag !== 6'd10) $display("FAIL bp_hold_tag got=%0d exp=10", wb_tag); else passed++;
      wb_ready = 1'b1;
      #1;
      total++; if (issue_ready !== 1'b1) $display("FAIL bp_ready_comb got=%b exp=1", issue_ready); else passed++;
      tick();
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      for (int i = 1; i < 4; i++) begin
         total++; if (wb_valid !== 1'b1 || wb_data !== 64'(2 * (i + 1)) || wb_tag !== 6'(10 + i)) $display("FAIL bp_drain%0d got=%b/%0h/%0d exp=1/%0h/%0d", i, wb_valid, wb_data, wb_tag, 2 * (i + 1), 10 + i); else passed++;
         tick();
      end
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle got=%b/%b exp=0/0", wb_valid, busy); else passed++;
   endtask

   task automatic test_full_push_pop();
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd0, 2'd0, 64'(20 + i), 64'd100, 6'(20 + i));
         tick();
      end
      wb_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k < 3) drive(1'b1, 3'd0, 2'd0, 64'(23 + k), 64'd100, 6'(23 + k));
         else drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
         if (k < 3) begin
            total++; if (issue_ready !== 1'b1) $display("FAIL fpp_ready%0d got=%b exp=1", k, issue_ready); else passed++;
         end
         total++; if (wb_valid !== 1'b1 || wb_data !== 64'(120 + k) || wb_tag !== 6'(20 + k)) $display("FAIL fpp_out%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, wb_valid, wb_data, wb_tag, 120 + k, 20 + k); else passed++;
         tick();
      end
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fpp_idle got=%b/%b exp=0/0", wb_valid, busy); else passed++;
   endtask

   task automatic test_illegal_unit();
      wb_ready = 1'b1;
      drive(1'b1, 3'd5, 2'd0, 64'd7, 64'd9, 6'd4);
      tick();
      drive(1'b1, 3'd0, 2'd0, 64'd7, 64'd9, 6'd5);
      total++; if (alu_unit !== 3'd5 || alu_enable !== 1'b1) $display("FAIL ill_alu_unit got=%0d/%b exp=5/1", alu_unit, alu_enable); else passed++;
      tick();
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd0 || wb_err !== 1'b1 || wb_tag !== 6'd4) $display("FAIL ill_entry got=%b/%0h/%b/%0d exp=1/0/1/4", wb_valid, wb_data, wb_err, wb_tag); else passed++;
      tick();
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd16 || wb_err !== 1'b0 || wb_tag !== 6'd5) $display("FAIL ill_next got=%b/%0h/%b/%0d exp=1/10/0/5", wb_valid, wb_data, wb_err, wb_tag); else passed++;
      tick();
   endtask

   task automatic test_flush();
      int seen = 0;
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd3, 2'd0, 64'hFF, 64'(30 + i), 6'(30 + i));
         tick();
      end
      flush = 1'b1;
      drive(1'b1, 3'd0, 2'd0, 64'd1, 64'd1, 6'd33);
      total++; if (issue_ready !== 1'b0) $display("FAIL fl_ready got=%b exp=0", issue_ready); else passed++;
      tick();
      flush = 1'b0;
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0 || alu_enable !== 1'b0) $display("FAIL fl_clear got=%b/%b/%b exp=0/0/0", wb_valid, busy, alu_enable); else passed++;
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (wb_valid) seen++;
         tick();
      end
      total++; if (seen !== 0) $display("FAIL fl_no_ghost got=%0d exp=0", seen); else passed++;
      drive(1'b1, 3'd2, 2'd0, 64'd3, 64'd4, 6'd34);
      tick();
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      tick();
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd48 || wb_tag !== 6'd34) $display("FAIL fl_after got=%b/%0h/%0d exp=1/30/34", wb_valid, wb_data, wb_tag); else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd0, 2'd0, 64'(40 + i), 64'd1, 6'(40 + i));
         tick();
      end
      rst = 1'b1;
      flush = 1'b1;
      drive(1'b1, 3'd0, 2'd0, 64'd1, 64'd1, 6'd43);
      tick();
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      total++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0 || alu_enable !== 1'b0) $display("FAIL rm_ctrl got=%b/%b/%b/%b exp=1/0/0/0", issue_ready, wb_valid, busy, alu_enable); else passed++;
      total++; if ({wb_data, wb_tag, wb_err, alu_unit, alu_op, alu_in1, alu_in2} !== 204'd0) $display("FAIL rm_data got=%h/%h/%b/%h exp=0", wb_data, wb_tag, wb_err, alu_in1); else passed++;
      wb_ready = 1'b1;
      drive(1'b1, 3'd0, 2'd0, 64'd9, 64'd9, 6'd44);
      tick();
      drive(1'b0, 3'd0, 2'd0, 64'd0, 64'd0, 6'd0);
      total++; if (wb_valid !== 1'b0 || alu_in1 !== 64'd9) $display("FAIL rm_lat1 got=%b/%0h exp=0/9", wb_valid, alu_in1); else passed++;
      tick();
      total++; if (wb_valid !== 1'b1 || wb_data !== 64'd18 || wb_tag !== 6'd44) $display("FAIL rm_lat2 got=%b/%0h/%0d exp=1/12/44", wb_valid, wb_data, wb_tag); else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_full_push_pop();
      test_illegal_unit();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
